// File: rtl/marc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// marc_ctrl_pkg
// Shared definitions for the mARC control unit: interface widths, one-hot
// state indices and encodings, instruction class codes, branch condition
// codes and PSR flag positions. Also provides the decode helper used to flag
// undefined instruction classes.
// -----------------------------------------------------------------------------
package marc_ctrl_pkg;

    // Interface widths
    localparam int NSTATE = 13;
    localparam int IR_W   = 16;
    localparam int STAT_W = 5;

    // One-hot state bit positions
    localparam int S_FETCH     = 0;
    localparam int S_DECODE    = 1;
    localparam int S_OPERAND   = 2;
    localparam int S_ALU       = 3;
    localparam int S_SHIFT     = 4;
    localparam int S_MEM       = 5;
    localparam int S_EA        = 6;
    localparam int S_BRANCH    = 7;
    localparam int S_CALL_SAVE = 8;
    localparam int S_CALL_JMP  = 9;
    localparam int S_RET       = 10;
    localparam int S_PC_DISP   = 11;
    localparam int S_PC_INC    = 12;

    // Instruction classes (ir[15:12]); ir[15]=0 is always an ALU instruction
    localparam logic [3:0] CLS_SHIFT = 4'b1000;
    localparam logic [3:0] CLS_MEM   = 4'b1001;
    localparam logic [3:0] CLS_BR    = 4'b1010;
    localparam logic [3:0] CLS_CALL  = 4'b1011;
    localparam logic [3:0] CLS_RET   = 4'b1100;
    localparam logic [3:0] CLS_HALT  = 4'b1111;

    // Branch condition codes (ir[10:8])
    localparam logic [2:0] COND_JMP = 3'b000;
    localparam logic [2:0] COND_BA  = 3'b001;
    localparam logic [2:0] COND_BNE = 3'b010;
    localparam logic [2:0] COND_BE  = 3'b011;
    localparam logic [2:0] COND_BG  = 3'b100;
    localparam logic [2:0] COND_BLE = 3'b101;
    localparam logic [2:0] COND_BGE = 3'b110;
    localparam logic [2:0] COND_BL  = 3'b111;

    // PSR flag bit positions
    localparam int PSR_Z = 0;
    localparam int PSR_N = 1;
    localparam int PSR_V = 2;

    // One-hot state encoding; the value of each member has bit S_x set
    typedef enum logic [NSTATE-1:0] {
        ST_FETCH     = 13'h0001,
        ST_DECODE    = 13'h0002,
        ST_OPERAND   = 13'h0004,
        ST_ALU       = 13'h0008,
        ST_SHIFT     = 13'h0010,
        ST_MEM       = 13'h0020,
        ST_EA        = 13'h0040,
        ST_BRANCH    = 13'h0080,
        ST_CALL_SAVE = 13'h0100,
        ST_CALL_JMP  = 13'h0200,
        ST_RET       = 13'h0400,
        ST_PC_DISP   = 13'h0800,
        ST_PC_INC    = 13'h1000
    } state_e;

    // True when the word belongs to no defined instruction class
    function automatic logic is_illegal_class(input logic [IR_W-1:0] word);
        logic result;
        if (word[15] == 1'b0) begin
            result = 1'b0;
        end else begin
            case (word[15:12])
                CLS_SHIFT, CLS_MEM, CLS_BR,
                CLS_CALL, CLS_RET, CLS_HALT: result = 1'b0;
                default:                     result = 1'b1;
            endcase
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// -----------------------------------------------------------------------------
// branch_cond_eval
// Combinational branch condition evaluator. The same logic is used by the
// output-logic condition terms, so it is kept as a standalone block.
// Ports:
//   status  in  STAT_W  PSR flags (bit0=Z, bit1=N, bit2=V)
//   cond    in  3       condition code from ir[10:8]
//   taken   out 1       branch is taken
// -----------------------------------------------------------------------------
module branch_cond_eval
    import marc_ctrl_pkg::*;
(
    input  logic [STAT_W-1:0] status,
    input  logic [2:0]        cond,
    output logic              taken
);

    logic z_s;
    logic nxv_s;
    logic unused_status_s;

    assign z_s   = status[PSR_Z];
    assign nxv_s = status[PSR_N] ^ status[PSR_V];

    // Upper PSR bits do not participate in any condition
    assign unused_status_s = ^status[STAT_W-1:3];

    // Condition table
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_JMP: taken = 1'b1;
            COND_BA:  taken = 1'b1;
            COND_BNE: taken = ~z_s;
            COND_BE:  taken = z_s;
            COND_BG:  taken = ~z_s & ~nxv_s;
            COND_BLE: taken = z_s | nxv_s;
            COND_BGE: taken = ~nxv_s;
            COND_BL:  taken = nxv_s;
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Next-state / state-register stage of the mARC control unit. Holds the
// instruction register and the 13-bit one-hot state vector that the output
// logic decodes into the datapath control word.
//
// Optional feature: define SINGLE_STEP_EN to add the step_mode/step ports.
// With step_mode=1 an instruction fetch completes only when mem_ready and
// step coincide; a step pulse without mem_ready is lost.
//
// Ports:
//   clk         in   1       rising-edge clock
//   rst_n       in   1       asynchronous active-low reset
//   mem_rdata   in   IR_W    instruction word from memory
//   mem_ready   in   1       memory handshake (used in FETCH and MEM only)
//   status      in   STAT_W  PSR flags, used in BRANCH only
//   resume      in   1       leave HALT, sampled in DECODE only
//   step_mode   in   1       single-step enable (SINGLE_STEP_EN only)
//   step        in   1       step pulse (SINGLE_STEP_EN only)
//   state       out  NSTATE  one-hot state vector
//   ir          out  IR_W    instruction register
//   halted      out  1       high while parked in DECODE on HALT
//   instr_done  out  1       high in the final state of an instruction
//   illegal     out  1       high in the DECODE cycle of an undefined class
// -----------------------------------------------------------------------------
module control_sequencer
    import marc_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IR_W-1:0]   mem_rdata,
    input  logic              mem_ready,
    input  logic [STAT_W-1:0] status,
    input  logic              resume,
`ifdef SINGLE_STEP_EN
    input  logic              step_mode,
    input  logic              step,
`endif
    output logic [NSTATE-1:0] state,
    output logic [IR_W-1:0]   ir,
    output logic              halted,
    output logic              instr_done,
    output logic              illegal
);

    state_e            state_r;
    state_e            state_nxt_s;
    logic [IR_W-1:0]   ir_r;
    logic [IR_W-1:0]   ir_nxt_s;
    logic              halted_r;
    logic              halted_nxt_s;
    logic              done_r;
    logic              done_nxt_s;
    logic              illegal_r;
    logic              illegal_nxt_s;
    logic              capture_s;
    logic              taken_s;

    // Fetch completion qualifier
`ifdef SINGLE_STEP_EN
    assign capture_s = mem_ready & (~step_mode | step);
`else
    assign capture_s = mem_ready;
`endif

    branch_cond_eval u_branch_cond_eval (
        .status (status),
        .cond   (ir_r[10:8]),
        .taken  (taken_s)
    );

    // Next state, IR capture and next values of the registered flags
    always_comb begin
        state_nxt_s   = state_r;
        ir_nxt_s      = ir_r;
        illegal_nxt_s = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (capture_s) begin
                    ir_nxt_s      = mem_rdata;
                    state_nxt_s   = ST_DECODE;
                    // Flag is raised during the DECODE cycle of the new word
                    illegal_nxt_s = is_illegal_class(mem_rdata);
                end else begin
                    state_nxt_s   = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (ir_r[15] == 1'b0) begin
                    if (ir_r[4] == 1'b1) begin
                        state_nxt_s = ST_OPERAND;
                    end else begin
                        state_nxt_s = ST_ALU;
                    end
                end else begin
                    case (ir_r[15:12])
                        CLS_SHIFT: state_nxt_s = ST_SHIFT;
                        CLS_MEM:   state_nxt_s = ST_EA;
                        CLS_BR:    state_nxt_s = ST_BRANCH;
                        CLS_CALL:  state_nxt_s = ST_CALL_SAVE;
                        CLS_RET:   state_nxt_s = ST_RET;
                        CLS_HALT: begin
                            if (resume) begin
                                state_nxt_s = ST_PC_INC;
                            end else begin
                                state_nxt_s = ST_DECODE;
                            end
                        end
                        // Undefined class completes as a NOP
                        default:   state_nxt_s = ST_PC_INC;
                    endcase
                end
            end
            ST_OPERAND:   state_nxt_s = ST_ALU;
            ST_ALU:       state_nxt_s = ST_PC_INC;
            ST_SHIFT:     state_nxt_s = ST_PC_INC;
            ST_EA:        state_nxt_s = ST_MEM;
            ST_MEM: begin
                if (mem_ready) begin
                    state_nxt_s = ST_PC_INC;
                end else begin
                    state_nxt_s = ST_MEM;
                end
            end
            ST_BRANCH: begin
                if (taken_s) begin
                    state_nxt_s = ST_PC_DISP;
                end else begin
                    state_nxt_s = ST_PC_INC;
                end
            end
            ST_CALL_SAVE: state_nxt_s = ST_CALL_JMP;
            ST_CALL_JMP:  state_nxt_s = ST_FETCH;
            ST_RET:       state_nxt_s = ST_FETCH;
            ST_PC_DISP:   state_nxt_s = ST_FETCH;
            ST_PC_INC:    state_nxt_s = ST_FETCH;
            // A corrupted (non one-hot) vector restarts at FETCH
            default:      state_nxt_s = ST_FETCH;
        endcase
    end

    // Flags are computed from the next state so that they line up with it
    always_comb begin
        halted_nxt_s = (state_nxt_s == ST_DECODE) && (ir_nxt_s[15:12] == CLS_HALT);
        done_nxt_s   = (state_nxt_s == ST_CALL_JMP) || (state_nxt_s == ST_RET) ||
                       (state_nxt_s == ST_PC_DISP)  || (state_nxt_s == ST_PC_INC);
    end

    // State vector, IR and output flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_FETCH;
            ir_r      <= {IR_W{1'b0}};
            halted_r  <= 1'b0;
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            ir_r      <= ir_nxt_s;
            halted_r  <= halted_nxt_s;
            done_r    <= done_nxt_s;
            illegal_r <= illegal_nxt_s;
        end
    end

    assign state      = state_r;
    assign ir         = ir_r;
    assign halted     = halted_r;
    assign instr_done = done_r;
    assign illegal    = illegal_r;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
// Directed bench. For each instruction an expected state trace is built from
// the instruction's class, fetch/memory wait counts, PSR value and halt length;
// the driver walks the trace and derives the handshake inputs from it, and a
// compare process checks all outputs against the trace every cycle.
// -----------------------------------------------------------------------------
module tb_control_sequencer;
    import marc_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [4:0]  status;
    logic        resume;
    logic        step_mode;
    logic        step;
    logic [12:0] state;
    logic [15:0] ir;
    logic        halted;
    logic        instr_done;
    logic        illegal;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .status     (status),
        .resume     (resume),
`ifdef SINGLE_STEP_EN
        .step_mode  (step_mode),
        .step       (step),
`endif
        .state      (state),
        .ir         (ir),
        .halted     (halted),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int          path[$];
    bit          chk_en = 1'b0;
    int          exp_idx;
    logic [15:0] exp_ir;
    logic        exp_halted;
    logic        exp_done;
    logic        exp_illegal;
    logic [15:0] prev_ir = 16'h0000;

    // Branch outcome from the signed/zero relation each mnemonic names
    function automatic bit taken_m(input int c, input bit z, input bit n, input bit v);
        case (c)
            0, 1:    return 1'b1;
            2:       return !z;
            3:       return z;
            4:       return !z && (n == v);
            5:       return z || (n != v);
            6:       return n == v;
            7:       return n != v;
            default: return 1'b0;
        endcase
    endfunction

    // Expected state trace of one instruction, starting at its first FETCH cycle
    task automatic build(input logic [15:0] w, input int fwait, input int mwait,
                         input logic [4:0] st, input int hold);
        path.delete();
        repeat (fwait + 1) path.push_back(0);
        path.push_back(1);
        if (!w[15]) begin
            if (w[4]) path.push_back(2);
            path.push_back(3);
            path.push_back(12);
        end else begin
            case (w[15:12])
                4'h8: begin path.push_back(4); path.push_back(12); end
                4'h9: begin
                    path.push_back(6);
                    repeat (mwait + 1) path.push_back(5);
                    path.push_back(12);
                end
                4'hA: begin
                    path.push_back(7);
                    path.push_back(taken_m(int'(w[10:8]), st[0], st[1], st[2]) ? 11 : 12);
                end
                4'hB: begin path.push_back(8); path.push_back(9); end
                4'hC: path.push_back(10);
                4'hF: begin
                    repeat (hold - 1) path.push_back(1);
                    path.push_back(12);
                end
                default: path.push_back(12);
            endcase
        end
    endtask

    // Walk the trace: publish expectations, drive inputs for this cycle.
    // Inputs irrelevant to the current state are driven to disruptive values.
    task automatic exec(input logic [15:0] w, input int fwait, input int mwait,
                        input logic [4:0] st, input int hold, input int stop_at);
        int s;
        int nx;
        build(w, fwait, mwait, st, hold);
        chk_en = 1'b1;
        for (int k = 0; k < path.size(); k++) begin
            s  = path[k];
            nx = (k + 1 < path.size()) ? path[k+1] : 0;
            exp_idx     = s;
            exp_ir      = (k > fwait) ? w : prev_ir;
            exp_halted  = (s == 1) && (w[15:12] == 4'hF);
            exp_illegal = (s == 1) && ((w[15:12] == 4'hD) || (w[15:12] == 4'hE));
            exp_done    = (s >= 9);
            mem_ready   = (s == 0) ? (nx == 1) : ((s == 5) ? (nx == 12) : 1'b1);
            mem_rdata   = (s == 0) ? w : ~w;
            status      = (s == 7) ? st : ~st;
            resume      = (s == 1) ? ((nx == 12) && (w[15:12] == 4'hF)) : 1'b1;
            if (k == stop_at) return;
            @(posedge clk);
            #1;
        end
        prev_ir = w;
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic [12:0] oh;
        if (chk_en) begin
            oh = 13'h0001 << exp_idx;
            chk("state", {19'd0, state}, {19'd0, oh});
            chk("ir", {16'd0, ir}, {16'd0, exp_ir});
            chk("halted", {31'd0, halted}, {31'd0, exp_halted});
            chk("instr_done", {31'd0, instr_done}, {31'd0, exp_done});
            chk("illegal", {31'd0, illegal}, {31'd0, exp_illegal});
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int zeros;
        rst_n     = 1'b0;
        mem_rdata = 16'h0000;
        mem_ready = 1'b0;
        status    = 5'd0;
        resume    = 1'b0;
        step_mode = 1'b0;
        step      = 1'b0;
        #12;
        chk("reset_state", {19'd0, state}, 32'h0000_0001);
        chk("reset_ir", {16'd0, ir}, 32'h0);
        chk("reset_flags", {29'd0, halted, instr_done, illegal}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Model pins (hand-derived traces)
        build(16'h0010, 0, 0, 5'd0, 0);
        chk("model_alu_len", path.size(), 32'd5);
        chk("model_alu_s2", path[2], 32'd2);
        build(16'h0000, 3, 0, 5'd0, 0);
        zeros = 0;
        foreach (path[i]) if (path[i] == 0) zeros++;
        chk("model_fetch_wait_s0", zeros, 32'd4);
        build(16'h9000, 0, 2, 5'd0, 0);
        chk("model_mem_seq", {path[1][3:0], path[2][3:0], path[3][3:0], path[4][3:0],
                              path[5][3:0], path[6][3:0]}, 32'h0016_555C);
        chk("model_bne_z1", {31'd0, taken_m(2, 1'b1, 1'b0, 1'b0)}, 32'd0);
        chk("model_bne_z0", {31'd0, taken_m(2, 1'b0, 1'b0, 1'b0)}, 32'd1);
        chk("model_bg_nv", {31'd0, taken_m(4, 1'b0, 1'b1, 1'b0)}, 32'd0);

        // ALU with operand fetch, then the hand-known IR value
        exec(16'h0010, 0, 0, 5'd0, 0, -1);
        chk("alu_ir_literal", {16'd0, ir}, 32'h0000_0010);
        // Fetch waits, ALU without operand
        exec(16'h0000, 3, 0, 5'd0, 0, -1);
        exec(16'h7FEF, 1, 0, 5'd0, 0, -1);
        // Load with memory waits
        exec(16'h9000, 0, 2, 5'd0, 0, -1);
        exec(16'h9123, 0, 0, 5'd0, 0, -1);
        // All branch conditions across Z and N^V
        for (int c = 0; c < 8; c++) begin
            for (int nv = 0; nv < 2; nv++) begin
                for (int z = 0; z < 2; z++) begin
                    logic [15:0] bw;
                    logic [4:0]  st;
                    bw = 16'hA000 | (16'(c) << 8);
                    st = {2'b00, 1'b0, nv[0], z[0]};
                    if (c[0]) st = {2'b11, nv[0], 1'b1, z[0]};   // N^V via N=V... varied pattern
                    if (c[0]) st[1] = ~st[2] ^ ~nv[0] ^ 1'b1;
                    exec(bw, 0, 0, st, 0, -1);
                end
            end
        end
        // Shift, call, return
        exec(16'h8ABC, 0, 0, 5'd0, 0, -1);
        exec(16'hB001, 2, 0, 5'd0, 0, -1);
        exec(16'hC000, 0, 0, 5'd0, 0, -1);
        // HALT held 10 cycles, then undefined classes
        exec(16'hF000, 0, 0, 5'd0, 10, -1);
        exec(16'hF00F, 0, 0, 5'd0, 1, -1);
        exec(16'hD000, 0, 0, 5'd0, 0, -1);
        exec(16'hE5A5, 0, 0, 5'd0, 0, -1);

        // Reset in the middle of a memory wait
        exec(16'h9000, 0, 5, 5'd0, 0, 4);
        chk_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midmem_reset_state", {19'd0, state}, 32'h0000_0001);
        chk("midmem_reset_ir", {16'd0, ir}, 32'h0);
        chk("midmem_reset_flags", {29'd0, halted, instr_done, illegal}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_ir = 16'h0000;
        @(posedge clk);
        #1;
        exec(16'h0010, 1, 0, 5'd0, 0, -1);

`ifdef SINGLE_STEP_EN
        chk_en    = 1'b0;
        step_mode = 1'b1;
        mem_rdata = 16'h8000;
        mem_ready = 1'b1;
        step      = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("step_hold_no_step", {19'd0, state}, 32'h0000_0001);
        end
        mem_ready = 1'b0;
        step      = 1'b1;
        @(posedge clk);
        #1;
        chk("step_lost_no_ready", {19'd0, state}, 32'h0000_0001);
        mem_ready = 1'b1;
        step      = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        chk("step_capture_state", {19'd0, state}, 32'h0000_0002);
        chk("step_capture_ir", {16'd0, ir}, 32'h0000_8000);
        step_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
`endif

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
